fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
Parametrised successor to the EX-stage forwarding logic. It generalises operand forwarding to NUM_SRC operands and NUM_STAGES producer stages, and adds the hazards that forwarding cannot cover:
- load-use stall detection;
- a register scoreboard for variable-latency (long) operations, with RAW and WAW stall;
- registered stall-reason tracking and a saturating stall counter.

It sits between ID/EX and the pipeline control. It drives the EX operand muxes and the ID/IF stall.

Parameters:
AW, 3, register address width; NREG = 2**AW
NUM_SRC, 2, source operands per instruction
NUM_STAGES, 2, forwarding producer stages after EX; index 0 = youngest (EX/MEM), index 1 = MEM/WB, ...
CNT_W, 16, stall counter width
SEL_W, $clog2(NUM_STAGES+1), width of one forward select

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
hold_i  in  1  downstream hold; pipeline does not advance
flush_i  in  1  kill instruction in ID this cycle
id_valid  in  1  valid instruction in ID
id_src_addr  in  NUM_SRC*AW  ID source registers, operand i at [i*AW +: AW]
id_src_used  in  NUM_SRC  operand i actually read
id_reg_write  in  1  ID instruction writes id_rdest
id_rdest  in  AW  ID destination
id_is_long  in  1  ID instruction is a long-latency op
ex_valid, ex_reg_write, ex_is_load  in  1 each  EX-stage instruction attributes
ex_rdest  in  AW  EX destination
ex_src_addr  in  NUM_SRC*AW  EX source registers
stg_valid, stg_reg_write  in  NUM_STAGES each  per producer stage
stg_rdest  in  NUM_STAGES*AW  per producer stage destination
long_done  in  1  long op writes back this cycle
long_done_rdest  in  AW  its destination
ex_fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k+1 = stage k
stall  out  1  hold IF/ID, insert bubble into EX
stall_reason  out  2  registered: 0 RUN, 1 LOAD, 2 SB_RAW, 3 SB_WAW
pending_o  out  NREG  scoreboard bits
stall_cnt  out  CNT_W  saturating count of stall cycles
sb_err  out  1  sticky: long_done to a non-pending register

Behaviour:
Forwarding (combinational):
- For each operand i, ex_fwd_sel[i] = k+1 for the lowest k with stg_valid[k] & stg_reg_write[k] & stg_rdest[k]==ex_src_addr[i]. Otherwise 0.
- Youngest stage wins.
- Register 0 is not special.

Hazard terms (combinational, on current-cycle values; each qualified by id_valid & ~flush_i):
- load_h: ex_valid & ex_reg_write & ex_is_load & some used operand matches ex_rdest.
- raw_h: some used operand has pending[src]=1.
- waw_h: id_reg_write & pending[id_rdest].

Stall output:
- stall = load_h | raw_h | waw_h.
- Priority for reason reporting: LOAD > SB_RAW > SB_WAW.
- The pending value used is the pre-update value. The cycle in which long_done fires still stalls; the release is visible the next cycle.

Advance:
- adv = id_valid & ~flush_i & ~stall & ~hold_i.

Scoreboard, each cycle:
- If long_done, clear pending[long_done_rdest].
- Then, if adv & id_is_long & id_reg_write, set pending[id_rdest]. Set wins over a same-register clear.
- long_done while pending[long_done_rdest]==0: no change; sb_err <= 1 (sticky until reset).
- hold_i does not block long_done clears.

Reason FSM (registered):
- States RUN, LOAD, SB_RAW, SB_WAW.
- Next state = reason of the current stall, or RUN when stall=0.
- A load-use stall lasts exactly one cycle, because the load leaves EX. If hold_i is active, the state is held and the load stall persists as long as EX is held.
- stall_reason = state.

Counter:
- stall_cnt increments on cycles with stall=1 & ~hold_i.
- Saturates at all-ones; no wrap.

Reset (async, rst_n=0):
- pending=0, state RUN, stall_cnt=0, sb_err=0.
- Combinational outputs follow their inputs.
- Reset mid long op: the pending bit is lost. A later long_done for it sets sb_err.

Flush:
- Suppresses stall and adv for the ID instruction.
- Does not clear the scoreboard; in-flight long ops still complete.

Decomposition:
- Shared package fwd_pkg: stall_reason_e enum, FWD_SEL_RF=0 constant, SEL_W function.
- One sub-module, fwd_scoreboard: pending vector, set/clear, sb_err.
- Forwarding priority and hazard logic stay in the top level.

Test Plan:
1. Forward priority: stg0 and stg1 both write r3; ex_src_addr[0]=3 -> ex_fwd_sel[0]=1. Drop stg0 valid -> 2. Drop both -> 0.
2. Load-use: EX load to r2, ID uses r2 on operand 1 -> stall=1 for one cycle, stall_reason=1 the next cycle, stall_cnt=1. Same with id_src_used[1]=0 -> no stall.
3. Long RAW: issue long op to r5. Next instruction reads r5 -> stall until the cycle after long_done_rdest=5; pending_o[5] 1 -> 0; reason=2 during the stall.
4. WAW plus same-cycle set/clear: long r4 pending; ID long write to r4 stalls (reason 3). On the long_done=4 cycle, ID still stalls; next cycle it issues and pending_o[4] stays 1.
5. Error and reset: long_done_rdest=6 with pending[6]=0 -> sb_err=1, sticky. Assert rst_n=0 mid-stall -> pending=0, stall_cnt=0, sb_err=0 immediately.
6. Saturation with CNT_W=3: hold stall for 10 cycles -> stall_cnt=7. Cycles with hold_i=1 are not counted.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
package fwd_pkg;

  // Why the front end is stalled. The encoding is visible on stall_reason.
  typedef enum logic [1:0] {
    RSN_RUN    = 2'd0,
    RSN_LOAD   = 2'd1,
    RSN_SB_RAW = 2'd2,
    RSN_SB_WAW = 2'd3
  } stall_reason_e;

  // A forward select of 0 means "take the register file value".
  localparam int FWD_SEL_RF = 0;

  // Width of one forward select: it must encode the register file and every stage.
  function automatic int fwd_sel_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Pending-write scoreboard for long-latency operations, with a sticky error
// flag for a completion that targets a register that is not pending.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int AW   = 3,
  parameter int NREG = 2 ** AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_i,
  input  logic [AW-1:0]   set_addr_i,
  input  logic            clr_i,
  input  logic [AW-1:0]   clr_addr_i,
  output logic [NREG-1:0] pending_o,
  output logic            sb_err_o
);

  logic [NREG-1:0] pending_q, pending_d;
  logic            err_q, err_d;

  // Clear on completion first, then set on issue, so an issue to the register
  // completing this cycle leaves it pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_addr_i] = 1'b0;
    if (set_i) pending_d[set_addr_i] = 1'b1;
    err_d = err_q | (clr_i & ~pending_q[clr_addr_i]);
  end

  // Scoreboard state; completions are accepted regardless of pipeline hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending_o = pending_q;
  assign sb_err_o  = err_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding plus the hazards forwarding cannot cover: load-use,
// and RAW/WAW against long-latency operations tracked in a scoreboard.
//
// Handshake: the ID instruction advances (adv) in a cycle where id_valid=1,
// flush_i=0, stall=0 and hold_i=0. stall is combinational on current-cycle
// inputs and the registered scoreboard; no other input waits on an output.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int AW         = 3,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = fwd_sel_w(NUM_STAGES),
  parameter int NREG       = 2 ** AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold_i,
  input  logic                     flush_i,
  input  logic                     id_valid,
  input  logic [NUM_SRC*AW-1:0]    id_src_addr,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     id_reg_write,
  input  logic [AW-1:0]            id_rdest,
  input  logic                     id_is_long,
  input  logic                     ex_valid,
  input  logic                     ex_reg_write,
  input  logic                     ex_is_load,
  input  logic [AW-1:0]            ex_rdest,
  input  logic [NUM_SRC*AW-1:0]    ex_src_addr,
  input  logic [NUM_STAGES-1:0]    stg_valid,
  input  logic [NUM_STAGES-1:0]    stg_reg_write,
  input  logic [NUM_STAGES*AW-1:0] stg_rdest,
  input  logic                     long_done,
  input  logic [AW-1:0]            long_done_rdest,
  output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel,
  output logic                     stall,
  output logic [1:0]               stall_reason,
  output logic [NREG-1:0]          pending_o,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic                     sb_err
);

  logic            id_live;
  logic            load_h, raw_h, waw_h;
  logic            adv;
  logic [NREG-1:0] pending;
  stall_reason_e   reason_d, state_q;
  logic [CNT_W-1:0] cnt_q;

  // Per-operand forward select; scanning oldest to youngest lets the youngest
  // matching stage overwrite, so the lowest stage index wins.
  always_comb begin
    ex_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_SEL_RF);
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (stg_valid[k] && stg_reg_write[k] &&
            (stg_rdest[k*AW +: AW] == ex_src_addr[i*AW +: AW])) begin
          ex_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  assign id_live = id_valid & ~flush_i;

  // Hazard terms against the EX load and the pre-update scoreboard.
  always_comb begin
    load_h = 1'b0;
    raw_h  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i]) begin
        if (ex_valid && ex_reg_write && ex_is_load &&
            (id_src_addr[i*AW +: AW] == ex_rdest)) begin
          load_h = 1'b1;
        end
        if (pending[id_src_addr[i*AW +: AW]]) raw_h = 1'b1;
      end
    end
    load_h = load_h & id_live;
    raw_h  = raw_h & id_live;
    waw_h  = id_live & id_reg_write & pending[id_rdest];
  end

  // Reason of the current stall, highest priority first.
  always_comb begin
    reason_d = RSN_RUN;
    if (load_h)     reason_d = RSN_LOAD;
    else if (raw_h) reason_d = RSN_SB_RAW;
    else if (waw_h) reason_d = RSN_SB_WAW;
  end

  assign stall = load_h | raw_h | waw_h;
  assign adv   = id_live & ~stall & ~hold_i;

  fwd_scoreboard #(
    .AW   (AW),
    .NREG (NREG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (adv & id_is_long & id_reg_write),
    .set_addr_i (id_rdest),
    .clr_i      (long_done),
    .clr_addr_i (long_done_rdest),
    .pending_o  (pending),
    .sb_err_o   (sb_err)
  );

  // Reason FSM: tracks the current stall reason, frozen while the pipe is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSN_RUN;
    end else if (!hold_i) begin
      state_q <= reason_d;
    end
  end

  // Saturating count of stall cycles in which the pipe could otherwise move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall && !hold_i && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_reason = state_q;
  assign pending_o    = pending;
  assign stall_cnt    = cnt_q;

endmodule
